// File: rtl/hyperbus_reg_cdc_src.sv
// hyperbus_reg_cdc_src: clk_sys-side source of the HyperBus reg-bus CDC.
// Packs one reg-bus request, 4-phase handshakes it across, returns the reply.
module hyperbus_reg_cdc_src #(
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned SyncStages   = 2,
  localparam int unsigned RegStrbWidth = RegDataWidth / 8,
  localparam int unsigned RegReqWidth  =
    RegAddrWidth + RegDataWidth + RegStrbWidth + 2,
  localparam int unsigned RegRspWidth  = RegDataWidth + 2
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_sys_ni,
  input  logic [RegAddrWidth-1:0] reg_addr_i,
  input  logic                    reg_write_i,
  input  logic [RegDataWidth-1:0] reg_wdata_i,
  input  logic [RegStrbWidth-1:0] reg_wstrb_i,
  input  logic                    reg_valid_i,
  output logic [RegDataWidth-1:0] reg_rdata_o,
  output logic                    reg_error_o,
  output logic                    reg_ready_o,
  output logic                    async_reg_req_req_o,
  input  logic                    async_reg_req_ack_i,
  output logic [RegReqWidth-1:0]  async_reg_req_data_o,
  input  logic                    async_reg_rsp_req_i,
  output logic                    async_reg_rsp_ack_o,
  input  logic [RegRspWidth-1:0]  async_reg_rsp_data_i,
  output logic                    busy_o
);

  typedef enum logic [2:0] {
    Idle,
    Req,
    ReqRel,
    WaitRsp,
    RspAck
  } state_e;

  state_e                  state_q;
  logic [SyncStages-1:0]   ack_sync_q;
  logic [SyncStages-1:0]   rsp_sync_q;
  logic                    ack_s;
  logic                    rsp_s;
  logic                    req_q;
  logic                    rsp_ack_q;
  logic [RegReqWidth-1:0]  req_data_q;
  logic [RegDataWidth-1:0] rdata_q;
  logic                    error_q;
  logic                    ready_q;
  logic                    unused_rsp_ready;

  // Remote's own ready bit is implied by the handshake itself.
  assign unused_rsp_ready = async_reg_rsp_data_i[0];

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      ack_sync_q <= '0;
      rsp_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SyncStages-2:0],
                     async_reg_req_ack_i};
      rsp_sync_q <= {rsp_sync_q[SyncStages-2:0],
                     async_reg_rsp_req_i};
    end
  end

  assign ack_s = ack_sync_q[SyncStages-1];
  assign rsp_s = rsp_sync_q[SyncStages-1];

  // A valid still high in the ready cycle belongs to the old transaction.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q    <= Idle;
      req_q      <= 1'b0;
      rsp_ack_q  <= 1'b0;
      req_data_q <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        Idle: begin
          if (reg_valid_i && !ready_q) begin
            req_data_q <= {reg_addr_i, reg_write_i,
                           reg_wdata_i, reg_wstrb_i, 1'b1};
            req_q      <= 1'b1;
            state_q    <= Req;
          end
        end
        Req: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= ReqRel;
          end
        end
        ReqRel: begin
          if (!ack_s) begin
            state_q <= WaitRsp;
          end
        end
        WaitRsp: begin
          if (rsp_s) begin
            rdata_q   <= async_reg_rsp_data_i[RegDataWidth+1:2];
            error_q   <= async_reg_rsp_data_i[1];
            rsp_ack_q <= 1'b1;
            state_q   <= RspAck;
          end
        end
        RspAck: begin
          if (!rsp_s) begin
            rsp_ack_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= Idle;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign async_reg_req_req_o  = req_q;
  assign async_reg_req_data_o = req_data_q;
  assign async_reg_rsp_ack_o  = rsp_ack_q;
  assign reg_rdata_o          = rdata_q;
  assign reg_error_o          = error_q;
  assign reg_ready_o          = ready_q;
  assign busy_o               = (state_q != Idle);

  // Early response strobe is a remote protocol violation.
  cover property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
    rsp_s && (state_q inside {Idle, Req, ReqRel}));

  assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
    rsp_s && !rsp_ack_q && (state_q != WaitRsp) |=> !rsp_ack_q);

  assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
    (state_q != Idle) |=> $stable(req_data_q));

endmodule

// File: tb/tb_hyperbus_reg_cdc_src.sv
// tb_hyperbus_reg_cdc_src: randomized bench for the reg-bus CDC source
// with a behavioural remote macro and reg-bus master.
module tb_hyperbus_reg_cdc_src;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int REQW = AW + DW + SW + 2;
  localparam int RSPW = DW + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   addr;
  logic            write;
  logic [DW-1:0]   wdata;
  logic [SW-1:0]   wstrb;
  logic            valid;
  logic [DW-1:0]   rdata_o;
  logic            error_o;
  logic            ready_o;
  logic            req_o;
  logic            ack;
  logic [REQW-1:0] req_data_o;
  logic            rsp_req;
  logic            rsp_ack_o;
  logic [RSPW-1:0] rsp_data;
  logic            busy_o;

  int errors    = 0;
  int checks    = 0;
  int ready_cnt = 0;
  logic prev_ready = 1'b0;
  logic [DW:0] rsp_q[$];

  always #5 clk = ~clk;

  hyperbus_reg_cdc_src dut (
    .clk_sys_i            (clk),
    .rst_sys_ni           (rst_n),
    .reg_addr_i           (addr),
    .reg_write_i          (write),
    .reg_wdata_i          (wdata),
    .reg_wstrb_i          (wstrb),
    .reg_valid_i          (valid),
    .reg_rdata_o          (rdata_o),
    .reg_error_o          (error_o),
    .reg_ready_o          (ready_o),
    .async_reg_req_req_o  (req_o),
    .async_reg_req_ack_i  (ack),
    .async_reg_req_data_o (req_data_o),
    .async_reg_rsp_req_i  (rsp_req),
    .async_reg_rsp_ack_o  (rsp_ack_o),
    .async_reg_rsp_data_i (rsp_data),
    .busy_o               (busy_o)
  );

  // Master-side observer: every ready pulse is recorded and must last 1 cycle.
  always @(negedge clk) begin
    if (rst_n && ready_o) begin
      ready_cnt++;
      rsp_q.push_back({rdata_o, error_o});
      checks++;
      if (prev_ready) begin
        errors++;
        $display("FAIL ready_pulse: ready_o=1 two cycles, required 1 cycle");
      end
    end
    prev_ready = ready_o;
  end

  task automatic wait_lvl(input string nm, input bit sel,
                          input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ((sel ? rsp_ack_o : req_o) === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timeout, got %b required %b", nm,
               sel ? rsp_ack_o : req_o, lvl);
    end
  endtask

  // Behavioural remote macro: 4-phase on both channels with given delays.
  task automatic remote_serve(input int d0, input int d1, input int d2,
                              input int d3, input logic [RSPW-1:0] rsp,
                              output logic [REQW-1:0] got);
    bit ok;
    logic [REQW-1:0] first;
    got = '0;
    wait_lvl("req_rise", 1'b0, 1'b1, ok);
    if (!ok) return;
    first = req_data_o;
    repeat (d0) @(posedge clk);
    #1;
    got = req_data_o;
    ack = 1'b1;
    checks++;
    if (got !== first) begin
      errors++;
      $display("FAIL req_data_stable: got %h required %h", got, first);
    end
    wait_lvl("req_fall", 1'b0, 1'b0, ok);
    if (!ok) return;
    repeat (d1) @(posedge clk);
    #1;
    ack = 1'b0;
    repeat (d2) @(posedge clk);
    #1;
    rsp_data = rsp;
    rsp_req  = 1'b1;
    wait_lvl("rsp_ack_rise", 1'b1, 1'b1, ok);
    if (!ok) return;
    repeat (d3) @(posedge clk);
    #1;
    rsp_req = 1'b0;
    wait_lvl("rsp_ack_fall", 1'b1, 1'b0, ok);
  endtask

  task automatic do_txn(input string nm, input logic [AW-1:0] a,
                        input logic w, input logic [DW-1:0] wd,
                        input logic [SW-1:0] ws, input logic [DW-1:0] rd,
                        input logic re, input int d0, input int d1,
                        input int d2, input int d3, input bit scramble,
                        input bit lat);
    logic [REQW-1:0] exp_req;
    logic [REQW-1:0] got_req;
    logic [DW:0]     got_rsp;
    int rc0;
    bit done;
    exp_req = {a, w, wd, ws, 1'b1};
    rsp_q.delete();
    rc0 = ready_cnt;
    fork
      begin
        @(posedge clk);
        #1;
        addr = a; write = w; wdata = wd; wstrb = ws; valid = 1'b1;
        @(negedge clk);
        if (lat) begin
          checks++;
          if (req_o !== 1'b0) begin
            errors++;
            $display("FAIL %s req_early: got %b required 0", nm, req_o);
          end
        end
        @(negedge clk);
        if (lat) begin
          checks++;
          if (req_o !== 1'b1) begin
            errors++;
            $display("FAIL %s req_latency: got %b required 1", nm, req_o);
          end
        end
        if (scramble) begin
          addr = $urandom; wdata = $urandom;
          write = 1'($urandom); wstrb = 4'($urandom);
        end
        done = (ready_o === 1'b1);
        for (int i = 0; i < 3000 && !done; i++) begin
          @(negedge clk);
          if (ready_o) done = 1'b1;
        end
        checks++;
        if (!done) begin
          errors++;
          $display("FAIL %s ready_timeout: got 0 required 1", nm);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
      end
      remote_serve(d0, d1, d2, d3, {rd, re, 1'b1}, got_req);
    join
    repeat (3) @(negedge clk);
    checks++;
    if (got_req !== exp_req) begin
      errors++;
      $display("FAIL %s req_data: got %h required %h", nm, got_req, exp_req);
    end
    checks++;
    if (ready_cnt - rc0 != 1) begin
      errors++;
      $display("FAIL %s ready_count: got %0d required 1", nm,
               ready_cnt - rc0);
    end
    got_rsp = (rsp_q.size() > 0) ? rsp_q.pop_front() : '1;
    checks++;
    if (got_rsp !== {rd, re}) begin
      errors++;
      $display("FAIL %s rsp: got %h required %h", nm, got_rsp, {rd, re});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      addr = $urandom; write = 1'($urandom); wdata = $urandom;
      wstrb = 4'($urandom); valid = 1'($urandom);
      ack = 1'($urandom); rsp_req = 1'($urandom);
      rsp_data = {$urandom, 2'($urandom)};
      @(negedge clk);
      checks++;
      if ({req_o, rsp_ack_o, req_data_o, rdata_o, error_o, ready_o,
           busy_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h required 0",
                 {req_o, rsp_ack_o, req_data_o, rdata_o, error_o,
                  ready_o, busy_o});
      end
    end
    @(posedge clk);
    #1;
    addr = '0; write = 1'b0; wdata = '0; wstrb = '0; valid = 1'b0;
    ack = 1'b0; rsp_req = 1'b0; rsp_data = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({req_o, rsp_ack_o, req_data_o, ready_o, busy_o} !== '0) begin
        errors++;
        $display("FAIL idle_after_reset: got %h required 0",
                 {req_o, rsp_ack_o, req_data_o, ready_o, busy_o});
      end
    end
  endtask

  task automatic test_write();
    do_txn("write", 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0,
           3, 1, 1, 1, 1'b0, 1'b1);
  endtask

  task automatic test_read();
    do_txn("read", 32'h04, 1'b0, 32'h0, 4'h0, 32'h0000_00A5, 1'b1,
           2, 2, 2, 2, 1'b0, 1'b1);
  endtask

  task automatic test_jitter();
    for (int n = 0; n < 50; n++) begin
      do_txn("jitter", $urandom, 1'($urandom), $urandom, 4'($urandom),
             $urandom, 1'($urandom),
             $urandom_range(1, 20), $urandom_range(1, 20),
             $urandom_range(1, 20), $urandom_range(1, 20), 1'b1, 1'b0);
    end
  endtask

  task automatic test_spurious();
    @(posedge clk);
    #1;
    rsp_req = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (rsp_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ack: got %b required 0", rsp_ack_o);
    end
    checks++;
    if ({busy_o, req_o} !== 2'b00) begin
      errors++;
      $display("FAIL spurious_idle: got %b required 00", {busy_o, req_o});
    end
    @(posedge clk);
    #1;
    rsp_req = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(posedge clk);
    #1;
    addr = 32'h20; write = 1'b0; wdata = '0; wstrb = '0; valid = 1'b1;
    wait_lvl("mid_req_rise", 1'b0, 1'b1, ok);
    @(posedge clk);
    #1;
    ack = 1'b1;
    wait_lvl("mid_req_fall", 1'b0, 1'b0, ok);
    @(posedge clk);
    #1;
    ack = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ({busy_o, req_o, rsp_ack_o} !== 3'b100) begin
      errors++;
      $display("FAIL mid_wait_rsp: got %b required 100",
               {busy_o, req_o, rsp_ack_o});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0; valid = 1'b0; ack = 1'b0;
    rsp_req = 1'b0; rsp_data = '0;
    @(negedge clk);
    checks++;
    if ({req_o, rsp_ack_o, busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset: got %b required 000",
               {req_o, rsp_ack_o, busy_o});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    do_txn("after_reset", 32'h08, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 1'b0,
           2, 3, 1, 2, 1'b0, 1'b1);
  endtask

  initial begin
    addr = '0; write = 1'b0; wdata = '0; wstrb = '0; valid = 1'b0;
    ack = 1'b0; rsp_req = 1'b0; rsp_data = '0;
    test_reset();
    test_write();
    test_read();
    test_jitter();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
